// File: rtl/count_var_pkg.sv
// rtl/count_var_pkg.sv - shared state encoding and default parameters for count_var_core
package count_var_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT       = 4;
    localparam int DEFAULT_MAX_DEFAULT = 15;

endpackage

// File: rtl/count_var_next.sv
// rtl/count_var_next.sv - combinational next-count and wrap computation for count_var_core
module count_var_next #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] max_val,
    input  logic             up,
    output logic [WIDTH-1:0] next_val,
    output logic             wrap,
    output logic             over
);

    always_comb begin
        next_val = count;
        wrap     = 1'b0;
        over     = (count > max_val);
        // A terminal shrunk below the current count snaps to the wrap target without a tc.
        if (over) begin
            next_val = up ? '0 : max_val;
        end else if (up) begin
            if (count == max_val) begin
                next_val = '0;
                wrap     = 1'b1;
            end else begin
                next_val = count + WIDTH'(1);
            end
        end else begin
            if (count == '0) begin
                next_val = max_val;
                wrap     = 1'b1;
            end else begin
                next_val = count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/count_var_core.sv
// rtl/count_var_core.sv - loadable variable-modulus up/down counter; COUNT_PARITY_EN adds count_par
module count_var_core
    import count_var_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int DEFAULT_MAX = DEFAULT_MAX_DEFAULT
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             load_1,
    input  logic [WIDTH-1:0] count_in,
    input  logic             max_wr,
    input  logic [WIDTH-1:0] max_in,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             load_err,
    output logic             running
`ifdef COUNT_PARITY_EN
    ,
    output logic             count_par
`endif
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] max_reg;
    logic [WIDTH-1:0] max_eff;
    logic [WIDTH-1:0] step_val;
    logic             step_wrap;
    logic             step_over;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             load_err_d;

    // A terminal written this cycle already governs the clamp and wrap decisions.
    assign max_eff = max_wr ? max_in : max_reg;

    count_var_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count    (count_out),
        .max_val  (max_eff),
        .up       (up),
        .next_val (step_val),
        .wrap     (step_wrap),
        .over     (step_over)
    );

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!load_1) begin
            state_next = LOAD;
        end else begin
            case (state)
                IDLE:    state_next = en ? RUN : IDLE;
                RUN:     state_next = en ? RUN : IDLE;
                LOAD:    state_next = en ? RUN : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        count_d    = count_out;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (!load_1) begin
            count_d    = (count_in > max_eff) ? max_eff : count_in;
            load_err_d = (count_in > max_eff);
        end else if (step_over) begin
            count_d = step_val;
        end else if (state == RUN && en) begin
            count_d = step_val;
            tc_d    = step_wrap;
        end
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            count_out <= '0;
            max_reg   <= WIDTH'(DEFAULT_MAX);
            tc        <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            count_out <= count_d;
            tc        <= tc_d;
            load_err  <= load_err_d;
            if (max_wr) begin
                max_reg <= max_in;
            end
        end
    end

`ifdef COUNT_PARITY_EN
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            count_par <= 1'b0;
        end else begin
            count_par <= ^count_d;
        end
    end
`endif

    assign running = (state == RUN);

endmodule

// File: tb/tb_count_var_core.sv
// tb/tb_count_var_core.sv - directed scoreboard bench for count_var_core
module tb_count_var_core;

    localparam int W = 4;

    logic         clk_50 = 1'b0;
    logic         reset;
    logic         load_1;
    logic [W-1:0] count_in;
    logic         max_wr;
    logic [W-1:0] max_in;
    logic         en;
    logic         up;
    logic [W-1:0] count_out;
    logic         tc;
    logic         load_err;
    logic         running;
`ifdef COUNT_PARITY_EN
    logic         count_par;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] count;
        logic         tc;
        logic         err;
        logic         run;
    } exp_t;

    exp_t sb[$];

    always #5 clk_50 = ~clk_50;

    count_var_core #(
        .WIDTH       (W),
        .DEFAULT_MAX (15)
    ) dut (
        .clk_50    (clk_50),
        .reset     (reset),
        .load_1    (load_1),
        .count_in  (count_in),
        .max_wr    (max_wr),
        .max_in    (max_in),
        .en        (en),
        .up        (up),
        .count_out (count_out),
        .tc        (tc),
        .load_err  (load_err),
        .running   (running)
`ifdef COUNT_PARITY_EN
        ,
        .count_par (count_par)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [W-1:0] c, input logic t,
                                 input logic e, input logic r);
        chk({tag, "_count"}, 8'(count_out), 8'(c));
        chk({tag, "_tc"}, 8'(tc), 8'(t));
        chk({tag, "_load_err"}, 8'(load_err), 8'(e));
        chk({tag, "_running"}, 8'(running), 8'(r));
`ifdef COUNT_PARITY_EN
        chk({tag, "_par"}, 8'(count_par), 8'(^c));
`endif
    endtask

    task automatic tick(input string tag, input logic [W-1:0] c, input logic t,
                        input logic e, input logic r);
        exp_t x;
        x.tag   = tag;
        x.count = c;
        x.tc    = t;
        x.err   = e;
        x.run   = r;
        sb.push_back(x);
        @(posedge clk_50);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 8'd1, 8'd0);
        end else begin
            x = sb.pop_front();
            check_outputs(x.tag, x.count, x.tc, x.err, x.run);
        end
    endtask

    initial begin
        reset    = 1'b0;
        load_1   = 1'b1;
        count_in = '0;
        max_wr   = 1'b0;
        max_in   = '0;
        en       = 1'b0;
        up       = 1'b1;
        repeat (2) @(posedge clk_50);
        #1;
        check_outputs("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Shrink the terminal to 10, count to 7, then reset asynchronously mid-cycle.
        en = 1'b1; up = 1'b1; max_wr = 1'b1; max_in = 4'd10;
        tick("t1_start", 4'd0, 1'b0, 1'b0, 1'b1);
        max_wr = 1'b0;
        for (int i = 1; i <= 7; i++) tick($sformatf("t1_up%0d", i), W'(i), 1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_outputs("t1_async", 4'd0, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        tick("t1_hold", 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Full up-count: terminal must be back to 15.
        en = 1'b1; up = 1'b1;
        tick("t2_start", 4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 15; i++) tick($sformatf("t2_up%0d", i), W'(i), 1'b0, 1'b0, 1'b1);
        tick("t2_wrap", 4'd0, 1'b1, 1'b0, 1'b1);
        en = 1'b0;
        tick("t2_enfall", 4'd0, 1'b0, 1'b0, 1'b0);

        // Down-count modulo 6.
        en = 1'b1; up = 1'b0; max_wr = 1'b1; max_in = 4'd5;
        tick("t3_start", 4'd0, 1'b0, 1'b0, 1'b1);
        max_wr = 1'b0;
        tick("t3_wrap_a", 4'd5, 1'b1, 1'b0, 1'b1);
        for (int i = 4; i >= 0; i--) tick($sformatf("t3_dn%0d", i), W'(i), 1'b0, 1'b0, 1'b1);
        tick("t3_wrap_b", 4'd5, 1'b1, 1'b0, 1'b1);
        tick("t3_dn4", 4'd4, 1'b0, 1'b0, 1'b1);

        // Loads against terminal 5: in range, at boundary, clamped (held in LOAD).
        load_1 = 1'b0; count_in = 4'd2;
        tick("t4_ld2", 4'd2, 1'b0, 1'b0, 1'b0);
        count_in = 4'd5;
        tick("t4_ld5", 4'd5, 1'b0, 1'b0, 1'b0);
        count_in = 4'd9;
        tick("t4_ld9", 4'd5, 1'b0, 1'b1, 1'b0);
        load_1 = 1'b1; en = 1'b1; up = 1'b1;
        tick("t4_release", 4'd5, 1'b0, 1'b0, 1'b1);
        tick("t4_wrap", 4'd0, 1'b1, 1'b0, 1'b1);

        // Load and terminal write together.
        load_1 = 1'b0; count_in = 4'd3; max_wr = 1'b1; max_in = 4'd2;
        tick("t5_ld", 4'd2, 1'b0, 1'b1, 1'b0);
        load_1 = 1'b1; max_wr = 1'b0;
        tick("t5_release", 4'd2, 1'b0, 1'b0, 1'b1);
        tick("t5_wrap", 4'd0, 1'b1, 1'b0, 1'b1);

        // Terminal shrunk below a running count of 12.
        load_1 = 1'b0; count_in = 4'd12; max_wr = 1'b1; max_in = 4'd15;
        tick("t6_ld12", 4'd12, 1'b0, 1'b0, 1'b0);
        load_1 = 1'b1; max_wr = 1'b0;
        tick("t6_release", 4'd12, 1'b0, 1'b0, 1'b1);
        max_wr = 1'b1; max_in = 4'd8;
        tick("t6_shrink", 4'd0, 1'b0, 1'b0, 1'b1);
        max_wr = 1'b0;
        for (int i = 1; i <= 7; i++) tick($sformatf("t6_up%0d", i), W'(i), 1'b0, 1'b0, 1'b1);

        // Terminal of zero pins the count and strobes tc every enabled cycle.
        max_wr = 1'b1; max_in = 4'd0;
        tick("t7_shrink", 4'd0, 1'b0, 1'b0, 1'b1);
        max_wr = 1'b0;
        tick("t7_pin_a", 4'd0, 1'b1, 1'b0, 1'b1);
        tick("t7_pin_b", 4'd0, 1'b1, 1'b0, 1'b1);
        up = 1'b0;
        tick("t7_pin_dn", 4'd0, 1'b1, 1'b0, 1'b1);

        // Async reset while a clamped load is being reported.
        load_1 = 1'b0; count_in = 4'd9;
        tick("t8_ld", 4'd0, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_outputs("t8_async", 4'd0, 1'b0, 1'b0, 1'b0);
        load_1 = 1'b1;
        tick("t8_hold", 4'd0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
